nlc_frame_serializer: RTL and testbench

- Sits directly downstream of the 16-channel NLC wrapper.
- Captures all 16 corrected 21-bit x_lin words on each NLC output-ready pulse, into a two-deep frame buffer.
- Streams the words out one channel per beat over a valid/ready handshake, ch0 first, ch15 last.
- Decouples the NLC's fixed-rate frame output from a back-pressuring consumer (host readout / FIFO), and flags dropped frames.

---
 rtl/nlc_frame_serializer_if.sv | 23 ++
 rtl/nlc_frame_serializer.sv | 157 +++++++++++++++
 tb/tb_nlc_frame_serializer.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/nlc_frame_serializer_if.sv
// Output stream bundle of the NLC frame serializer: one channel word per beat
// over a valid/ready handshake, plus channel index, last flag and error term.
interface nlc_frame_serializer_if #(
    parameter int DATA_W = 21,
    parameter int CH_W   = 4
);
    logic              out_valid_o;
    logic              out_ready_i;
    logic [DATA_W-1:0] out_data_o;
    logic [CH_W-1:0]   out_ch_o;
    logic              out_last_o;
    logic [DATA_W:0]   out_err_o;

    modport master (
        output out_valid_o, out_data_o, out_ch_o, out_last_o, out_err_o,
        input  out_ready_i
    );

    modport slave (
        input  out_valid_o, out_data_o, out_ch_o, out_last_o, out_err_o,
        output out_ready_i
    );
endinterface

// File: rtl/nlc_frame_serializer.sv
// Two-deep frame buffer that captures a full NLC x_lin frame per pulse and streams it
// out one channel per beat. Optional macro NLC_FRAME_ERR_EN adds the x_lin - x_ref term.
module nlc_frame_serializer #(
    parameter int NUM_CH = 16,
    parameter int DATA_W = 21,
    parameter int CH_W   = 4,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     frame_vld_i,
    input  logic [NUM_CH*DATA_W-1:0] x_lin_i,
    input  logic [DATA_W-1:0]        x_ref_i,
    nlc_frame_serializer_if.master   out_if,
    output logic                     ovf_o,
    input  logic                     ovf_clr_i,
    output logic [CNT_W-1:0]         frame_cnt_o,
    output logic [CNT_W-1:0]         drop_cnt_o
);
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t            state_reg, state_next;
    logic [1:0]        count_reg, count_next;
    logic              wr_ptr_reg, wr_ptr_next;
    logic              rd_ptr_reg, rd_ptr_next;
    logic [CH_W-1:0]   ch_idx_reg, ch_idx_next;
    logic [DATA_W-1:0] out_data_reg, word_next;
    logic [CH_W-1:0]   out_ch_reg;
    logic              out_last_reg;
    logic [DATA_W:0]   out_err_reg, err_next;
    logic              ovf_reg, ovf_next;
    logic [CNT_W-1:0]  frame_cnt_reg, frame_cnt_next;
    logic [CNT_W-1:0]  drop_cnt_reg, drop_cnt_next;

    logic capture, drop, fire, final_beat, load, bypass;
    logic [CNT_W-1:0] drop_base;

    logic [DATA_W-1:0] x_lin_w  [NUM_CH];
    logic [DATA_W-1:0] bank_mem [2][NUM_CH];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_unpack
            assign x_lin_w[gi] = x_lin_i[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // The bank being read is never the bank being written while count>0,
    // so the oldest undelivered frame cannot be overwritten.
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int i = 0; i < NUM_CH; i++) begin
                bank_mem[wr_ptr_reg][i] <= x_lin_w[i];
            end
        end
    end

`ifdef NLC_FRAME_ERR_EN
    logic [DATA_W-1:0] ref_mem [2];
    logic [DATA_W-1:0] ref_next;

    always_ff @(posedge clk) begin
        if (capture) begin
            ref_mem[wr_ptr_reg] <= x_ref_i;
        end
    end

    always_comb begin
        ref_next = bypass ? x_ref_i : ref_mem[rd_ptr_next];
        err_next = {1'b0, word_next} - {1'b0, ref_next};
    end
`else
    logic unused_ref;
    assign unused_ref = ^x_ref_i;
    assign err_next   = '0;
`endif

    always_comb begin
        capture    = frame_vld_i && (count_reg != 2'd2);
        drop       = frame_vld_i && (count_reg == 2'd2);
        fire       = (state_reg == SEND) && out_if.out_ready_i;
        final_beat = fire && (ch_idx_reg == LAST_CH);

        count_next = count_reg;
        case ({capture, final_beat})
            2'b10:   count_next = count_reg + 2'd1;
            2'b01:   count_next = count_reg - 2'd1;
            default: count_next = count_reg;
        endcase
        state_next = (count_next != 2'd0) ? SEND : IDLE;

        wr_ptr_next = wr_ptr_reg ^ capture;
        rd_ptr_next = rd_ptr_reg ^ final_beat;

        ch_idx_next = ch_idx_reg;
        if (final_beat) begin
            ch_idx_next = '0;
        end else if (fire) begin
            ch_idx_next = ch_idx_reg + 1'b1;
        end

        // Refresh the presented word only when a new one becomes visible;
        // otherwise the output registers hold (stall or idle).
        load   = (count_next != 2'd0) && (fire || (count_reg == 2'd0));
        // Next word lives in the bank being written this very edge.
        bypass = capture && (wr_ptr_reg == rd_ptr_next);
        word_next = bypass ? x_lin_w[ch_idx_next] : bank_mem[rd_ptr_next][ch_idx_next];

        ovf_next       = drop ? 1'b1 : (ovf_clr_i ? 1'b0 : ovf_reg);
        drop_base      = ovf_clr_i ? '0 : drop_cnt_reg;
        drop_cnt_next  = (drop && (drop_base != '1)) ? drop_base + 1'b1 : drop_base;
        frame_cnt_next = final_beat ? frame_cnt_reg + 1'b1 : frame_cnt_reg;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            count_reg     <= '0;
            wr_ptr_reg    <= 1'b0;
            rd_ptr_reg    <= 1'b0;
            ch_idx_reg    <= '0;
            out_data_reg  <= '0;
            out_ch_reg    <= '0;
            out_last_reg  <= 1'b0;
            out_err_reg   <= '0;
            ovf_reg       <= 1'b0;
            frame_cnt_reg <= '0;
            drop_cnt_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            count_reg     <= count_next;
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            ch_idx_reg    <= ch_idx_next;
            ovf_reg       <= ovf_next;
            frame_cnt_reg <= frame_cnt_next;
            drop_cnt_reg  <= drop_cnt_next;
            if (load) begin
                out_data_reg <= word_next;
                out_ch_reg   <= ch_idx_next;
                out_last_reg <= (ch_idx_next == LAST_CH);
                out_err_reg  <= err_next;
            end
        end
    end

    assign out_if.out_valid_o = (state_reg == SEND);
    assign out_if.out_data_o  = out_data_reg;
    assign out_if.out_ch_o    = out_ch_reg;
    assign out_if.out_last_o  = out_last_reg && (state_reg == SEND);
    assign out_if.out_err_o   = out_err_reg;
    assign ovf_o              = ovf_reg;
    assign frame_cnt_o        = frame_cnt_reg;
    assign drop_cnt_o         = drop_cnt_reg;
endmodule

// File: tb/tb_nlc_frame_serializer.sv
// Directed bench for nlc_frame_serializer; expected values are hand-computed
// (frame word n = base + n*step). Honours NLC_FRAME_ERR_EN for the error term.
module tb_nlc_frame_serializer;
    localparam int NUM_CH = 16;
    localparam int DATA_W = 21;
    localparam int CH_W   = 4;
    localparam int CNT_W  = 16;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     frame_vld_i;
    logic [NUM_CH*DATA_W-1:0] x_lin_i;
    logic [DATA_W-1:0]        x_ref_i;
    logic                     ovf_o;
    logic                     ovf_clr_i;
    logic [CNT_W-1:0]         frame_cnt_o;
    logic [CNT_W-1:0]         drop_cnt_o;

    int n_cmp = 0;
    int n_err = 0;

    nlc_frame_serializer_if #(.DATA_W(DATA_W), .CH_W(CH_W)) out_if ();

    nlc_frame_serializer #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .CH_W(CH_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .frame_vld_i(frame_vld_i),
        .x_lin_i(x_lin_i),
        .x_ref_i(x_ref_i),
        .out_if(out_if),
        .ovf_o(ovf_o),
        .ovf_clr_i(ovf_clr_i),
        .frame_cnt_o(frame_cnt_o),
        .drop_cnt_o(drop_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [NUM_CH*DATA_W-1:0] make_frame(input int base, input int step);
        logic [NUM_CH*DATA_W-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_CH; i++) v[i*DATA_W +: DATA_W] = DATA_W'(base + i*step);
        return v;
    endfunction

    task automatic do_reset();
        reset       = 1'b0;
        frame_vld_i = 1'b0;
        ovf_clr_i   = 1'b0;
        out_if.out_ready_i = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic capture_frame(input int base, input int step);
        x_lin_i     = make_frame(base, step);
        frame_vld_i = 1'b1;
        tick();
        frame_vld_i = 1'b0;
    endtask

    // Checks nbeats consecutive beats with ready high; one line per beat.
    task automatic expect_stream(input int base, input int step, input int start_ch, input int nbeats);
        int ch;
        out_if.out_ready_i = 1'b1;
        for (int i = 0; i < nbeats; i++) begin
            ch = start_ch + i;
            $display("beat ch=%0d data=%0d last=%0b", out_if.out_ch_o, out_if.out_data_o, out_if.out_last_o);
            check_val("beat_valid", 64'(out_if.out_valid_o), 64'd1);
            check_val("beat_ch", 64'(out_if.out_ch_o), 64'(ch));
            check_val("beat_data", 64'(out_if.out_data_o), 64'(base + ch*step));
            check_val("beat_last", 64'(out_if.out_last_o), 64'(ch == NUM_CH-1));
            tick();
        end
    endtask

    initial begin
        int exp_ch;
        logic [DATA_W:0] exp_err;
        x_lin_i = '0;
        x_ref_i = '0;
        do_reset();

        // reset state
        check_val("rst_valid", 64'(out_if.out_valid_o), 64'd0);
        check_val("rst_data", 64'(out_if.out_data_o), 64'd0);
        check_val("rst_ch", 64'(out_if.out_ch_o), 64'd0);
        check_val("rst_ovf", 64'(ovf_o), 64'd0);
        check_val("rst_frame_cnt", 64'(frame_cnt_o), 64'd0);
        check_val("rst_drop_cnt", 64'(drop_cnt_o), 64'd0);

        // single frame, back-to-back beats
        out_if.out_ready_i = 1'b1;
        capture_frame(1, 4);
        expect_stream(1, 4, 0, 16);
        check_val("t1_idle_valid", 64'(out_if.out_valid_o), 64'd0);
        check_val("t1_idle_last", 64'(out_if.out_last_o), 64'd0);
        check_val("t1_hold_data", 64'(out_if.out_data_o), 64'd61);
        check_val("t1_frame_cnt", 64'(frame_cnt_o), 64'd1);
        $display("frame 1 done, frame_cnt=%0d", frame_cnt_o);

        // ready toggling 1/0: 16 beats over 31 cycles
        do_reset();
        capture_frame(100, 1);
        exp_ch = 0;
        for (int cyc = 0; cyc < 31; cyc++) begin
            out_if.out_ready_i = (cyc % 2 == 0);
            check_val("t2_valid", 64'(out_if.out_valid_o), 64'd1);
            check_val("t2_ch", 64'(out_if.out_ch_o), 64'(exp_ch));
            check_val("t2_data", 64'(out_if.out_data_o), 64'(100 + exp_ch));
            tick();
            if (cyc % 2 == 0) exp_ch++;
        end
        check_val("t2_done_valid", 64'(out_if.out_valid_o), 64'd0);
        check_val("t2_frame_cnt", 64'(frame_cnt_o), 64'd1);
        $display("toggle frame done, beats=%0d", exp_ch);

        // three frames back-to-back under back-pressure: third dropped
        do_reset();
        frame_vld_i = 1'b1;
        x_lin_i = make_frame(200, 1);
        tick();
        x_lin_i = make_frame(300, 1);
        tick();
        check_val("t3_stall_data", 64'(out_if.out_data_o), 64'd200);
        x_lin_i = make_frame(400, 1);
        tick();
        frame_vld_i = 1'b0;
        check_val("t3_ovf", 64'(ovf_o), 64'd1);
        check_val("t3_drop_cnt", 64'(drop_cnt_o), 64'd1);
        check_val("t3_stall_ch", 64'(out_if.out_ch_o), 64'd0);
        expect_stream(200, 1, 0, 16);
        expect_stream(300, 1, 0, 16);
        check_val("t3_done_valid", 64'(out_if.out_valid_o), 64'd0);
        check_val("t3_frame_cnt", 64'(frame_cnt_o), 64'd2);
        $display("overflow test done, drop_cnt=%0d", drop_cnt_o);

        // new frame on the same edge as the final beat: no bubble
        capture_frame(500, 1);
        expect_stream(500, 1, 0, 15);
        check_val("t4_last_beat", 64'(out_if.out_last_o), 64'd1);
        x_lin_i = make_frame(600, 1);
        frame_vld_i = 1'b1;
        tick();
        frame_vld_i = 1'b0;
        expect_stream(600, 1, 0, 16);
        check_val("t4_done_valid", 64'(out_if.out_valid_o), 64'd0);
        check_val("t4_frame_cnt", 64'(frame_cnt_o), 64'd4);
        check_val("t4_ovf_sticky", 64'(ovf_o), 64'd1);

        // drop together with clear: drop wins, count restarts at 1
        out_if.out_ready_i = 1'b0;
        frame_vld_i = 1'b1;
        tick();
        tick();
        ovf_clr_i = 1'b1;
        tick();
        frame_vld_i = 1'b0;
        ovf_clr_i   = 1'b0;
        check_val("t4_clrdrop_ovf", 64'(ovf_o), 64'd1);
        check_val("t4_clrdrop_cnt", 64'(drop_cnt_o), 64'd1);
        ovf_clr_i = 1'b1;
        tick();
        ovf_clr_i = 1'b0;
        check_val("t4_clr_ovf", 64'(ovf_o), 64'd0);
        check_val("t4_clr_cnt", 64'(drop_cnt_o), 64'd0);
        $display("clear test done, ovf=%0b drop_cnt=%0d", ovf_o, drop_cnt_o);

        // reset pulsed mid-frame at ch7
        do_reset();
        out_if.out_ready_i = 1'b1;
        capture_frame(700, 1);
        expect_stream(700, 1, 0, 7);
        check_val("t5_at_ch7", 64'(out_if.out_ch_o), 64'd7);
        reset = 1'b0;
        #1;
        check_val("t5_rst_valid", 64'(out_if.out_valid_o), 64'd0);
        check_val("t5_rst_data", 64'(out_if.out_data_o), 64'd0);
        check_val("t5_rst_ch", 64'(out_if.out_ch_o), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("t5_post_valid", 64'(out_if.out_valid_o), 64'd0);
        end
        capture_frame(800, 1);
        expect_stream(800, 1, 0, 16);
        check_val("t5_frame_cnt", 64'(frame_cnt_o), 64'd1);
        $display("mid-frame reset test done");

        // error term at ch3: 990 - 1000
        do_reset();
        out_if.out_ready_i = 1'b1;
        x_ref_i = DATA_W'(1000);
        x_lin_i = make_frame(1, 4);
        x_lin_i[3*DATA_W +: DATA_W] = DATA_W'(990);
        frame_vld_i = 1'b1;
        tick();
        frame_vld_i = 1'b0;
        tick();
        tick();
        tick();
`ifdef NLC_FRAME_ERR_EN
        exp_err = 22'h3FFFF6;
`else
        exp_err = '0;
`endif
        check_val("t6_ch", 64'(out_if.out_ch_o), 64'd3);
        check_val("t6_data", 64'(out_if.out_data_o), 64'd990);
        check_val("t6_err", 64'(out_if.out_err_o), 64'(exp_err));
        $display("err beat ch=%0d err=%0h", out_if.out_ch_o, out_if.out_err_o);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
